// File: rtl/stage_exe_muldiv.sv
// rtl/stage_exe_muldiv.sv - iterative RV M-extension multiply/divide execute stage
module stage_exe_muldiv #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int HAS_W    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [2:0]      in_funct3,
    input  logic            in_word32,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            exe_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] LO32 = {XLEN{1'b1}} >> (XLEN - 32);
    localparam logic [CW-1:0] MUL_CYC_X = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] MUL_CYC_W = CW'(32 / MUL_BITS);
    localparam logic [CW-1:0] DIV_CYC_X = CW'(XLEN);
    localparam logic [CW-1:0] DIV_CYC_W = CW'(32);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;          // multiplier digits, or dividend shifting into quotient
    logic [XLEN-1:0]   b_q, b_d;          // divisor magnitude
    logic [2*XLEN-1:0] mcand_q, mcand_d;  // multiplicand, shifted up one digit per cycle
    logic [2*XLEN-1:0] acc_q, acc_d;      // running product, or partial remainder in the low half
    logic [2:0]        fn_q, fn_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;      // product / quotient must be negated at the end
    logic              negr_q, negr_d;    // remainder must be negated at the end
    logic [XLEN-1:0]   res_q, res_d;

    logic              accept, word_in, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, last, ge;
    logic [XLEN-1:0]   wmask, a_w, b_w, a_mag, b_mag, fast_res;
    logic [MUL_BITS-1:0] digit;
    logic [2*XLEN-1:0] mul_acc, prod;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [XLEN-1:0]   quo_nx, rem_nx, q_fin, r_fin, mul_fin;

    // Word results keep the low 32 bits and replicate bit 31 upward
    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] r, input logic w);
        return w ? ((r & LO32) | ({XLEN{r[31]}} & ~LO32)) : r;
    endfunction

    assign accept = (state_q == S_IDLE) && in_valid && !flush;
    assign last   = (cnt_q == CW'(1));

    // Decode the incoming op: effective width, operand magnitudes and divide fast paths
    always_comb begin
        word_in  = (HAS_W != 0) && (XLEN == 64) && in_word32;
        wmask    = word_in ? LO32 : {XLEN{1'b1}};
        a_w      = in_a & wmask;
        b_w      = in_b & wmask;
        a_sgn    = word_in ? in_a[31] : in_a[XLEN-1];
        b_sgn    = word_in ? in_b[31] : in_b[XLEN-1];
        a_neg    = a_sgn && (in_funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
        b_neg    = b_sgn && (in_funct3 inside {3'd1, 3'd4, 3'd6});
        a_mag    = a_neg ? ((-a_w) & wmask) : a_w;
        b_mag    = b_neg ? ((-b_w) & wmask) : b_w;
        div_zero = (b_w == '0);
        div_ovf  = (in_funct3 inside {3'd4, 3'd6}) && (a_w == (wmask ^ (wmask >> 1))) && (b_w == wmask);
        if (div_zero) begin
            fast_res = in_funct3[1] ? a_w : wmask;
        end else begin
            fast_res = in_funct3[1] ? '0 : a_w;
        end
        fast_res = fit(fast_res, word_in);
    end

    // One multiply digit step and one restoring-divide step, plus final sign fix-up
    always_comb begin
        digit    = a_q[MUL_BITS-1:0];
        mul_acc  = acc_q + mcand_q * (2*XLEN)'(digit);
        prod     = neg_q ? -mul_acc : mul_acc;
        if (fn_q == 3'd0) begin
            mul_fin = prod[XLEN-1:0];
        end else if (word_q) begin
            mul_fin = XLEN'(prod >> 32);
        end else begin
            mul_fin = prod[2*XLEN-1:XLEN];
        end
        rem_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        ge       = ~rem_diff[XLEN];
        rem_nx   = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {a_q[XLEN-2:0], ge};
        q_fin    = neg_q ? -quo_nx : quo_nx;
        r_fin    = negr_q ? -rem_nx : rem_nx;
    end

    // Datapath next state: load on accept, iterate in MUL/DIV, latch result on the last step
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        word_d  = word_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        res_d   = res_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            fn_d   = in_funct3;
            word_d = word_in;
            neg_d  = a_neg ^ b_neg;
            negr_d = a_neg;
            if (!in_funct3[2]) begin
                mcand_d = (2*XLEN)'(a_mag);
                a_d     = b_mag;
                acc_d   = '0;
                cnt_d   = word_in ? MUL_CYC_W : MUL_CYC_X;
            end else if (div_zero || div_ovf) begin
                res_d = fast_res;
                cnt_d = '0;
            end else begin
                // Word dividends are left-aligned so the quotient bits always come from the top
                a_d   = word_in ? (a_mag << (XLEN - 32)) : a_mag;
                b_d   = b_mag;
                acc_d = '0;
                cnt_d = word_in ? DIV_CYC_W : DIV_CYC_X;
            end
        end else if (state_q == S_MUL) begin
            acc_d   = mul_acc;
            mcand_d = mcand_q << MUL_BITS;
            a_d     = a_q >> MUL_BITS;
            cnt_d   = cnt_q - CW'(1);
            if (last) res_d = fit(mul_fin, word_q);
        end else if (state_q == S_DIV) begin
            acc_d = (2*XLEN)'(rem_nx);
            a_d   = quo_nx;
            cnt_d = cnt_q - CW'(1);
            if (last) res_d = fit(fn_q[1] ? r_fin : q_fin, word_q);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            fn_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides both completion and accept
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    if (!in_funct3[2])           state_d = S_MUL;
                    else if (div_zero || div_ovf) state_d = S_DONE;
                    else                          state_d = S_DIV;
                end
                S_MUL:  if (last) state_d = S_DONE;
                S_DIV:  if (last) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs
    always_comb begin
        out_valid  = (state_q == S_DONE) && !flush;
        exe_ready  = (state_q == S_DONE) || ((state_q == S_IDLE) && !in_valid);
        out_result = res_q;
    end
endmodule

// File: tb/tb_stage_exe_muldiv.sv
// tb/tb_stage_exe_muldiv.sv - directed and randomized checks of stage_exe_muldiv
module tb_stage_exe_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_word32;
    logic [2:0]  in_funct3;
    logic [63:0] in_a, in_b;
    logic        exe_ready, out_valid;
    logic [63:0] out_result;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    stage_exe_muldiv #(.XLEN(64), .MUL_BITS(4), .HAS_W(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_funct3(in_funct3), .in_word32(in_word32), .in_a(in_a), .in_b(in_b),
        .exe_ready(exe_ready), .out_valid(out_valid), .out_result(out_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: wide signed math on the W-bit operands
    function automatic logic [63:0] ref_result(input logic [2:0] f, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, r;
        int sh;
        if (w) begin
            sa = $signed(a[31:0]); sb = $signed(b[31:0]);
            ua = {96'b0, a[31:0]}; ub = {96'b0, b[31:0]};
            sh = 32;
        end else begin
            sa = $signed(a); sb = $signed(b);
            ua = {64'b0, a}; ub = {64'b0, b};
            sh = 64;
        end
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> sh;
            3'd2: r = (sa * ub) >>> sh;
            3'd3: r = (ua * ub) >>> sh;
            3'd4: r = (sb == 0) ? -128'sd1 : sa / sb;
            3'd5: r = (ub == 0) ? -128'sd1 : ua / ub;
            3'd6: r = (sb == 0) ? sa : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return w ? {{32{r[31]}}, r[31:0]} : r[63:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        int n;
        logic [63:0] aw, bw, mn, ones;
        n    = w ? 32 : 64;
        ones = w ? 64'h0000_0000_FFFF_FFFF : '1;
        mn   = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        aw   = a & ones;
        bw   = b & ones;
        if (f < 3'd4) return n / 4 + 1;
        if (bw == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && aw == mn && bw == ones) return 1;
        return n + 1;
    endfunction

    task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_funct3 = f; in_word32 = w; in_a = a; in_b = b; in_valid = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, out_result, exp_res);
        check({tag, " ready_done"}, {63'b0, exe_ready}, 64'd1);
        @(negedge clk);
        check({tag, " one_shot"}, {63'b0, out_valid}, 64'd0);
        check({tag, " held"}, out_result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        issue(f, w, a, b);
        #1 check({tag, " ready_busy"}, {63'b0, exe_ready}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_funct3 = ~f; in_word32 = ~w;
        wait_done(tag, exp_res, exp_lat);
    endtask

    initial begin
        int n, vcount;
        int times[3];
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word32 = 1'b0;
        in_funct3 = '0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {63'b0, out_valid}, 64'd0);
        check("reset out_result", out_result, 64'd0);
        check("reset exe_ready", {63'b0, exe_ready}, 64'd1);
        rst = 1'b0;

        run_op("mul", 3'd0, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 17);
        run_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 17);
        run_op("div", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
        run_op("rem", 3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
        run_op("divu", 3'd5, 1'b0, 64'd7, 64'd2, 64'd3, 65);
        run_op("div_by0", 3'd4, 1'b0, 64'd42, 64'd0, '1, 1);
        run_op("rem_by0", 3'd6, 1'b0, 64'd42, 64'd0, 64'd42, 1);
        run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 9);

        // Flush ten cycles into a divide; an op offered with the flush is dropped
        issue(3'd4, 1'b0, -64'sd7, 64'd2);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd3; in_a = '1; in_b = '1;
        #1 check("flush out_valid", {63'b0, out_valid}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_funct3 = 3'd0; in_a = 64'd3; in_b = -64'sd5;
        @(negedge clk);
        check("post_flush out_valid", {63'b0, out_valid}, 64'd0);
        check("post_flush ready", {63'b0, exe_ready}, 64'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done("after_flush", 64'hFFFF_FFFF_FFFF_FFF1, 17);

        // Reset in the middle of a multiply abandons it
        issue(3'd0, 1'b0, 64'd5, 64'd7);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid out_result", out_result, 64'd0);
        check("rst_mid ready", {63'b0, exe_ready}, 64'd1);
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("rst_mid no_valid", 64'(vcount), 64'd0);

        // Back-to-back with in_valid held: accepts only from IDLE, one out_valid each
        issue(3'd0, 1'b0, 64'd3, -64'sd5);
        n = 0; vcount = 0;
        while (vcount < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                check("b2b result", out_result, 64'hFFFF_FFFF_FFFF_FFF1);
                times[vcount] = n;
                vcount++;
                if (vcount == 3) in_valid = 1'b0;
            end
        end
        check("b2b count", 64'(vcount), 64'd3);
        check("b2b t0", 64'(times[0]), 64'd17);
        check("b2b t1", 64'(times[1]), 64'd35);
        check("b2b t2", 64'(times[2]), 64'd53);
        @(negedge clk);
        check("b2b tail", {63'b0, out_valid}, 64'd0);

        // Randomized ops against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            if (f inside {3'd1, 3'd2, 3'd3}) w = 1'b0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 64'($urandom_range(1, 9)) * (($urandom_range(0, 1) != 0) ? 64'd1 : '1);
                2: a = 64'($urandom_range(0, 100));
                3: begin
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = '1;
                end
                default: ;
            endcase
            run_op("rand", f, w, a, b, ref_result(f, w, a, b), ref_latency(f, w, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
